// File: rtl/uart_pkg.sv
// Shared UART types and line levels, used by the receiver and the planned transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every CLK_DIV clocks.
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output and sticky overrun.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  if (CLK_DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 ||
      DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_params
    $error("uart_rx: illegal parameter set");
  end

  logic                 rx_p0, rx_p1, rxs, prev_rxs, tick, done, ferr_q;
  logic [SW-1:0]        s_cnt;
  logic [3:0]           b_cnt;
  logic [DATA_BITS-1:0] shift;
  uart_rx_state_e       state;

`ifdef UART_RX_PARITY_EN
  logic perr_q;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d ^ p) != 1'(PARITY_ODD);
  endfunction
`endif

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Synchronizer: rx -> rx_p0 -> rx_p1 (= rxs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= UART_IDLE_LEVEL;
      rx_p1 <= UART_IDLE_LEVEL;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rxs = rx_p1;

  // Data shift register, LSB arrives first so samples enter at the MSB
  always_ff @(posedge clk) begin
    if (tick && state == DATA && s_cnt == S_LAST) begin
      shift <= {rxs, shift[DATA_BITS-1:1]};
    end
  end

  // Frame FSM, advances on oversample ticks only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_cnt    <= '0;
      b_cnt    <= '0;
      prev_rxs <= UART_IDLE_LEVEL;
      ferr_q   <= 1'b0;
      done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (tick) begin
        prev_rxs <= rxs;
        case (state)
          IDLE: begin
            // Edge-triggered so a line held low (break) cannot re-arm
            if (prev_rxs == UART_IDLE_LEVEL && rxs == UART_START_LEVEL) begin
              s_cnt  <= '0;
              b_cnt  <= '0;
              ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_q <= 1'b0;
`endif
              state  <= START;
            end
          end
          START: begin
            if (s_cnt == S_MID) begin
              s_cnt <= '0;
              state <= (rxs == UART_START_LEVEL) ? DATA : IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              if (b_cnt == 4'(DATA_BITS - 1)) begin
                b_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                b_cnt <= b_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (s_cnt == S_LAST) begin
              s_cnt  <= '0;
              perr_q <= parity_bad(shift, rxs);
              state  <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              if (rxs != UART_IDLE_LEVEL) ferr_q <= 1'b1;
              if (b_cnt == 4'(STOP_BITS - 1)) begin
                b_cnt <= '0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                b_cnt <= b_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (done) begin
      rx_data   <= shift;
      frame_err <= ferr_q;
      rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_q;
`endif
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue expected words, a monitor checks each accepted word.
module tb_uart_rx;

  localparam int BIT = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_drop = 1'b0;

  uart_rx #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted word against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (chk_drop) begin
      chk_drop = 1'b0;
      checks++;
      if (rx_valid) begin
        errors++;
        $display("FAIL valid_pulse: rx_valid still 1 after accept, expected 0");
      end
    end
    if (rst_n && rx_valid && rx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%0h fe=%b pe=%b, expected no word",
                 rx_data, frame_err, parity_err);
      end else begin
        e = sb.pop_front();
        if (rx_data !== e.d || frame_err !== e.fe || parity_err !== e.pe) begin
          errors++;
          $display("FAIL word: got data=%0h fe=%b pe=%b, expected data=%0h fe=%b pe=%b",
                   rx_data, frame_err, parity_err, e.d, e.fe, e.pe);
        end
      end
      chk_drop = 1'b1;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    rx = 1'b1;
    rx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    idle(1);

    // Clean frame, consumer ready
    sb.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(2);
    check("a5_overrun", 32'(overrun), 32'h0);

    // Short low glitch must be rejected as a false start
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(12);
    check("glitch_no_valid", 32'(rx_valid), 32'h0);

    // Stop bit low, line stays low afterwards
    sb.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (3) drive_bit(1'b0);
    idle(2);
    check("3c_frame_err_held", 32'(frame_err), 32'h1);

    // Break: whole frame low
    sb.push_back('{d: 8'h00, fe: 1'b1, pe: 1'b0});
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (3) drive_bit(1'b0);
    idle(2);
    check("break_frame_err", 32'(frame_err), 32'h1);

    // Normal frame after break
    sb.push_back('{d: 8'hC3, fe: 1'b0, pe: 1'b0});
    send_frame(8'hC3, ^8'hC3, 1'b1);
    idle(2);
    check("c3_frame_err", 32'(frame_err), 32'h0);

    // Overrun: two words with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle(2);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_flag", 32'(overrun), 32'h1);
    sb.push_back('{d: 8'h22, fe: 1'b0, pe: 1'b0});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    rx_ready = 1'b1;
    idle(1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit should be 1
    sb.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2);
    sb.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
`endif

    // Reset in the middle of a 0xFF frame
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("midreset");
    rst_n = 1'b1;
    repeat (5) drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b1);
`endif
    drive_bit(1'b1);
    idle(1);
    sb.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(3);

    check("all_words_seen", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised, clocked UART receiver with oversampled start-bit validation, mid-bit sampling, an optional parity check, framing and overrun detection, and a valid/ready output handshake. It sits between the asynchronous serial pin `rx` and byte-level consumers such as a FIFO or a register bank. It is the synchronous, configurable successor to the existing free-running `uart` block.

## Interface
- `CLK_DIV`, 4: clocks per oversample tick (≥1).
- `OVERSAMPLE`, 16: ticks per bit (even, ≥4).
- `DATA_BITS`, 8: data bits per frame (5–9), LSB first.
- `STOP_BITS`, 1: stop bits checked (1 or 2).
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Used only with `UART_RX_PARITY_EN`.
- `clk` input, 1: clock.
- `rst_n` input, 1: asynchronous active-low reset.
- `rx` input, 1: serial line, asynchronous, idle high.
- `rx_data` output, `DATA_BITS`: received word.
- `rx_valid` output, 1: word available.
- `rx_ready` input, 1: consumer accepts the word.
- `frame_err` output, 1: a stop bit was sampled 0 for the held word.
- `parity_err` output, 1: parity mismatch for the held word. Tied 0 without the macro.
- `overrun` output, 1: sticky. Set when a word was lost.

## Operation
- `rx` passes through a 2-flop synchronizer with reset value 1. All logic uses the synchronized value `rxs`.
- Tick generator: counter 0..`CLK_DIV`-1, wraps. `tick` pulses for one clock at `CLK_DIV`-1. Reset sets the counter to 0.
- `prev_rxs` holds the `rxs` value from the previous tick.
- FSM advances only on `tick`. Bit counter `s_cnt` runs 0..`OVERSAMPLE`-1.
- IDLE: when `prev_rxs`=1 and `rxs`=0, set `s_cnt`=0 and go to START. A line held low never re-arms the FSM.
- START: at `s_cnt`=`OVERSAMPLE`/2-1, sample the line.
  - `rxs`=1: false start, return to IDLE.
  - `rxs`=0: clear `s_cnt`, go to DATA.
- DATA: sample at `s_cnt`=`OVERSAMPLE`-1, then shift the sample into the MSB of the shift register (right shift). After `DATA_BITS` samples, go to PARITY (macro defined) or STOP.
- PARITY: sample one bit. Error if the XOR of data and the parity bit ≠ `PARITY_ODD`.
- STOP: sample `STOP_BITS` bits. Any 0 sets the frame-error flag for this frame.
- After the last stop sample, go to IDLE and load outputs on the next clock:
  - `rx_data` ← shift register.
  - `frame_err` and `parity_err` ← this frame's flags.
  - `rx_valid` ← 1.
- Handshake: the word transfers on a clock where `rx_valid`=1 and `rx_ready`=1. `rx_valid` drops the next clock unless a new word loads in the same clock.
- Load while `rx_valid`=1 and `rx_ready`=0: new data overwrites the held word and `overrun` ← 1.
- Load and accept in the same clock: new word held, `rx_valid` stays 1, no overrun.
- `overrun` clears only on reset.
- Break (line low for a whole frame): frame completes with `frame_err`=1 and `rx_data`=0. The FSM then waits in IDLE until the line returns high.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0.
  - FSM in IDLE, counters 0, synchronizer 1s, `prev_rxs`=1.
- Bit period is `CLK_DIV`×`OVERSAMPLE` clocks. Samples fall at mid-bit ± 1 tick, plus 2 clocks of synchronizer lag.
- `rx_valid` rises exactly 1 clock after the tick that samples the last stop bit.
- Reset mid-frame aborts the frame with no partial output. The first falling edge after reset release is detected normally.
- `rx_ready` is not registered. Acceptance takes effect at the same clock edge.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: the PARITY state exists, frames carry one parity bit, and `parity_err` is driven.
  - Undefined: no PARITY state, frames have no parity bit, `parity_err` is constant 0, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` holds:
  - `uart_rx_state_e` enum {IDLE, START, DATA, PARITY, STOP}.
  - Shared constants `UART_IDLE_LEVEL`=1'b1 and `UART_START_LEVEL`=1'b0.
- Sub-module `uart_baud_tick` (parameter `CLK_DIV`; ports `clk`, `rst_n`, `tick`) produces the oversample tick. It is reused by the planned transmitter.

## Test plan
All scenarios use CLK_DIV=4, OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1, giving a 64-clock bit.
- Frame 0xA5, `rx_ready`=1 → `rx_data`=0xA5, one-clock `rx_valid` pulse, all errors 0.
- 20-clock low glitch on an idle line → FSM returns to IDLE, no `rx_valid`.
- Frame 0x3C with stop bit driven 0 → `rx_data`=0x3C, `frame_err`=1. No new frame until the line returns high.
- Frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data`=0x22, `overrun`=1. A later `rx_ready` pulse clears `rx_valid`, but `overrun` stays 1.
- Macro defined, PARITY_ODD=0: frame 0x07 with parity bit 0 → `parity_err`=1. Same frame with parity bit 1 → `parity_err`=0.
- `rst_n` asserted mid-data of 0xFF → all outputs 0. A following 0x5A frame is received correctly.
